// File: rtl/nuc_loader.sv
// Streams ASCII nucleotides into a 2-bit-per-entry memory, one write per accepted
// character, until a newline terminator or until the memory is full.
module nuc_loader #(
  parameter int W  = 65536,
  parameter int AW = $clog2(W)
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_char,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_data,
  output logic [AW:0]   count,
  output logic          done,
  output logic          error,
  output logic          full,
  output logic [1:0]    fsm_state
);

  // Handshake: a character transfers on a rising edge where in_valid and in_ready
  // are both 1; in_ready is registered and high exactly while the FSM is in LOAD.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned LAST = W - 1;

  state_t     state;
  logic       is_nuc;
  logic [1:0] code;

  always_comb begin
    is_nuc = 1'b1;
    code   = 2'b00;
    case (in_char)
      8'h41, 8'h61: code = 2'b00;
      8'h43, 8'h63: code = 2'b01;
      8'h47, 8'h67: code = 2'b10;
      8'h54, 8'h74: code = 2'b11;
      default:      is_nuc = 1'b0;
    endcase
  end

  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= 2'b00;
      count    <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      full     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            done     <= 1'b0;
            count    <= '0;
            error    <= 1'b0;
            full     <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (is_nuc) begin
              mem_we   <= 1'b1;
              mem_addr <= count[AW-1:0];
              mem_data <= code;
              count    <= count + 1'b1;
              // The write that fills the memory still lands next cycle from DONE.
              if (count == LAST[AW:0]) begin
                state    <= DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
                full     <= 1'b1;
              end
            end else if (in_char == 8'h0A) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nuc_loader.sv
// Bench for nuc_loader: a full-size and a 4-entry instance share one input stream and
// are compared every cycle against a behavioural load model.
module tb_nuc_loader;

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;

  logic        b_ready, b_we, b_done, b_error, b_full;
  logic [15:0] b_addr;
  logic [1:0]  b_data, b_state;
  logic [16:0] b_count;

  logic        s_ready, s_we, s_done, s_error, s_full;
  logic [1:0]  s_addr;
  logic [1:0]  s_data, s_state;
  logic [2:0]  s_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model per instance: 0 = big (W=65536), 1 = small (W=4).
  int   m_w[2] = '{65536, 4};
  int   m_phase[2];   // 0 waiting for start, 1 loading, 2 finished
  int   m_cnt[2];
  bit   m_err[2], m_full[2], m_we[2];
  int   m_addr[2], m_data[2];
  logic [17:0] exp_q0[$];
  logic [17:0] exp_q1[$];

  nuc_loader dut_big (
    .clock(clock), .reset_L(reset_L), .start(start), .in_valid(in_valid),
    .in_char(in_char), .in_ready(b_ready), .mem_we(b_we), .mem_addr(b_addr),
    .mem_data(b_data), .count(b_count), .done(b_done), .error(b_error),
    .full(b_full), .fsm_state(b_state)
  );

  nuc_loader #(.W(4)) dut_small (
    .clock(clock), .reset_L(reset_L), .start(start), .in_valid(in_valid),
    .in_char(in_char), .in_ready(s_ready), .mem_we(s_we), .mem_addr(s_addr),
    .mem_data(s_data), .count(s_count), .done(s_done), .error(s_error),
    .full(s_full), .fsm_state(s_state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int code_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    if (u == "A") return 0;
    if (u == "C") return 1;
    if (u == "G") return 2;
    if (u == "T") return 3;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_full[i] = 0;
      m_we[i] = 0; m_addr[i] = 0; m_data[i] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_update(input int i, input logic st, input logic v, input logic [7:0] c);
    int cd;
    m_we[i] = 0;
    if (m_phase[i] != 1) begin
      if (st) begin
        m_phase[i] = 1; m_cnt[i] = 0; m_err[i] = 0; m_full[i] = 0;
      end
    end else if (v) begin
      cd = code_of(c);
      if (cd >= 0) begin
        if (i == 0) exp_q0.push_back({m_cnt[i][15:0], cd[1:0]});
        else        exp_q1.push_back({m_cnt[i][15:0], cd[1:0]});
        m_we[i] = 1;
        m_cnt[i]++;
        if (m_cnt[i] == m_w[i]) begin
          m_phase[i] = 2; m_full[i] = 1;
        end
      end else if (c == 8'h0A) begin
        m_phase[i] = 2;
      end else begin
        m_err[i] = 1;
      end
    end
  endtask

  task automatic check_dut(input int i);
    logic [17:0] e;
    string p;
    logic r, we, dn, er, fl;
    logic [31:0] cnt, ad, da;
    p = (i == 0) ? "big" : "small";
    if (i == 0) begin
      r = b_ready; we = b_we; dn = b_done; er = b_error; fl = b_full;
      cnt = 32'(b_count); ad = 32'(b_addr); da = 32'(b_data);
    end else begin
      r = s_ready; we = s_we; dn = s_done; er = s_error; fl = s_full;
      cnt = 32'(s_count); ad = 32'(s_addr); da = 32'(s_data);
    end
    if (m_we[i]) begin
      e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      m_addr[i] = int'(e[17:2]);
      m_data[i] = int'(e[1:0]);
    end
    chk({p, "_in_ready"}, 32'(r), 32'(m_phase[i] == 1));
    chk({p, "_done"}, 32'(dn), 32'(m_phase[i] == 2));
    chk({p, "_mem_we"}, 32'(we), 32'(m_we[i]));
    chk({p, "_mem_addr"}, ad, m_addr[i]);
    chk({p, "_mem_data"}, da, m_data[i]);
    chk({p, "_count"}, cnt, m_cnt[i]);
    chk({p, "_error"}, 32'(er), 32'(m_err[i]));
    chk({p, "_full"}, 32'(fl), 32'(m_full[i]));
  endtask

  task automatic step(input logic st, input logic v, input logic [7:0] c);
    start = st; in_valid = v; in_char = c;
    for (int i = 0; i < 2; i++) model_update(i, st, v, c);
    @(posedge clock);
    #1;
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 2; i++) check_dut(i);
  endtask

  task automatic send(input string s);
    for (int k = 0; k < s.len(); k++) step(1'b0, 1'b1, s[k]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_L = 1'b0; start = 1'b0; in_valid = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) check_dut(i);
    @(posedge clock);
    #1;
    @(negedge clock);
    reset_L = 1'b1;
    step(1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] pool [12] = '{"A", "C", "G", "T", "a", "c", "g", "t", "X", "z", 8'h0A, "A"};

  initial begin
    model_reset();
    do_reset();

    // Idle ignores characters until start.
    step(1'b0, 1'b1, "A");

    step(1'b1, 1'b0, 8'h00);
    send("ACGT\n");
    step(1'b0, 1'b0, 8'h00);
    chk("acgt_count", 32'(b_count), 4);
    chk("acgt_done", 32'(b_done), 1);
    chk("small_full_after_acgt", 32'(s_full), 1);

    step(1'b1, 1'b0, 8'h00);
    send("aXg\n");
    step(1'b0, 1'b0, 8'h00);
    chk("axg_count", 32'(b_count), 2);
    chk("axg_error", 32'(b_error), 1);

    step(1'b1, 1'b0, 8'h00);
    send("CCCCC");
    step(1'b0, 1'b0, 8'h00);
    chk("c5_small_count", 32'(s_count), 4);
    chk("c5_small_ready", 32'(s_ready), 0);
    send("\n");

    step(1'b1, 1'b0, 8'h00);
    send("CCC\n");
    step(1'b0, 1'b0, 8'h00);
    chk("wm1_small_full", 32'(s_full), 0);
    chk("wm1_small_done", 32'(s_done), 1);

    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, "G");
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, "T");
    step(1'b0, 1'b0, 8'h00);
    chk("gap_count", 32'(b_count), 2);
    send("\n");

    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, "A");
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    chk("rst_count", 32'(b_count), 0);

    step(1'b1, 1'b0, 8'h00);
    send("G\n");
    step(1'b1, 1'b0, 8'h00);
    send("T\n");
    step(1'b0, 1'b0, 8'h00);
    chk("reload_count", 32'(b_count), 1);
    chk("reload_full", 32'(b_full), 0);

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           pool[$urandom_range(0, 11)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
